piso_serializer: RTL and testbench

Parallel-in/serial-out transmitter: accepts a WIDTH-bit word over a valid/ready handshake and shifts it out one bit per accepted beat, LSB first, with a frame-end marker. It is the transmit end of the registered serial lane: it drives a 1-bit `ser_*` stream into the matching serial-to-parallel capture register bank. All state uses flops with asynchronous active-high reset.

---
 rtl/piso_serializer.sv | 88 ++++++++
 tb/tb_piso_serializer.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/piso_serializer.sv
// Parallel-in/serial-out transmitter: valid/ready word in, LSB-first bit stream out with frame-end marker.
// Optional even-parity trailer beat when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             ser_out,
  output logic             ser_valid,
  output logic             ser_last,
  input  logic             ser_ready
);

`ifdef PISO_PARITY_EN
  localparam int unsigned BEATS = WIDTH + 1;
`else
  localparam int unsigned BEATS = WIDTH;
`endif
  localparam int unsigned CW = $clog2(WIDTH + 2);
  localparam logic [CW-1:0] LAST_CNT = CW'(BEATS - 1);

  typedef enum logic {IDLE, SHIFT} state_t;

  state_t           state;
  logic [WIDTH-1:0] shreg;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             load;
  logic             beat;
  logic             fill;

  assign cnt_nxt = cnt + 1'b1;
  assign beat    = ser_valid && ser_ready;
  assign load    = in_valid && in_ready;
  assign ser_out = shreg[0];

  // Zero-bubble handoff: the last beat's acceptance frees the register on the same edge.
  assign in_ready = !rst && ((state == IDLE) || ((state == SHIFT) && ser_last && ser_ready));

`ifdef PISO_PARITY_EN
  logic par;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      par <= 1'b0;
    end else if (load) begin
      par <= ^in_data;
    end
  end

  // Parity enters at the top while shifting so it reaches bit 0 right after the last data bit.
  assign fill = par;
`else
  assign fill = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      shreg     <= '0;
      cnt       <= '0;
      ser_valid <= 1'b0;
      ser_last  <= 1'b0;
    end else if (load) begin
      state     <= SHIFT;
      shreg     <= in_data;
      cnt       <= '0;
      ser_valid <= 1'b1;
      ser_last  <= 1'b0;
    end else if (beat) begin
      cnt <= cnt_nxt;
      if (ser_last) begin
        // Clearing here keeps ser_out low while idle.
        state     <= IDLE;
        shreg     <= '0;
        ser_valid <= 1'b0;
        ser_last  <= 1'b0;
      end else begin
        shreg    <= {fill, shreg[WIDTH-1:1]};
        ser_last <= (cnt_nxt == LAST_CNT);
      end
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// Self-checking bench for piso_serializer: directed frames plus randomized traffic against a frame-level model.
module tb_piso_serializer;
  localparam int unsigned W = 8;
`ifdef PISO_PARITY_EN
  localparam int unsigned BEATS = W + 1;
`else
  localparam int unsigned BEATS = W;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         ser_out;
  logic         ser_valid;
  logic         ser_last;
  logic         ser_ready;

  always #5 clk = ~clk;

  piso_serializer #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .ser_out  (ser_out),
    .ser_valid(ser_valid),
    .ser_last (ser_last),
    .ser_ready(ser_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: the frame in flight as a list of bits plus a position.
  bit busy = 1'b0;
  int pos  = 0;
  bit fbits[$];
  bit got_q[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [63:0] fpack(input logic [W-1:0] d);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < W; i++) v[i] = d[i];
    if (BEATS > W) v[W] = ^d;
    return v;
  endfunction

  function automatic logic [63:0] pack_got();
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < got_q.size() && i < 64; i++) v[i] = got_q[i];
    return v;
  endfunction

  // Called at a negedge; applies inputs, checks, advances one clock, returns at the next negedge.
  task automatic step(input logic v, input logic [W-1:0] d, input logic r);
    bit exp_last, exp_ready, acc, xfer;
    in_valid  = v;
    in_data   = d;
    ser_ready = r;
    #1;
    exp_last  = busy && (pos == BEATS - 1);
    exp_ready = !busy || (exp_last && r);
    check("ser_valid", 64'(ser_valid), 64'(busy));
    check("ser_out",   64'(ser_out),   busy ? 64'(fbits[pos]) : 64'd0);
    check("ser_last",  64'(ser_last),  64'(exp_last));
    check("in_ready",  64'(in_ready),  64'(exp_ready));
    acc  = v && exp_ready;
    xfer = busy && r;
    if (ser_valid && r) got_q.push_back(ser_out);
    @(posedge clk);
    if (xfer) begin
      pos++;
      if (pos == BEATS) busy = 1'b0;
    end
    if (acc) begin
      fbits.delete();
      for (int i = 0; i < W; i++) fbits.push_back(d[i]);
      if (BEATS > W) fbits.push_back(^d);
      pos  = 0;
      busy = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic apply_reset();
    rst = 1'b1;
    #1;
    check("rst_valid", 64'(ser_valid), 64'd0);
    check("rst_out",   64'(ser_out),   64'd0);
    check("rst_last",  64'(ser_last),  64'd0);
    check("rst_ready", 64'(in_ready),  64'd0);
    busy = 1'b0;
    pos  = 0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    logic [3:0] bp;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_data   = '0;
    ser_ready = 1'b0;
    @(negedge clk);
    apply_reset();

    // Basic frame
    got_q.delete();
    step(1'b1, 8'hA5, 1'b1);
    for (int i = 0; i < BEATS; i++) step(1'b0, '0, 1'b1);
    check("basic_cnt",  64'(got_q.size()), 64'(BEATS));
    check("basic_bits", pack_got(), fpack(8'hA5));

    // Back-to-back with in_valid held
    got_q.delete();
    step(1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 2 * BEATS; i++) step(i < BEATS, 8'h80, 1'b1);
    check("b2b_cnt",  64'(got_q.size()), 64'(2 * BEATS));
    check("b2b_bits", pack_got(), fpack(8'h01) | (fpack(8'h80) << BEATS));

    // Backpressure
    got_q.delete();
    bp = 4'b1001;
    step(1'b1, 8'h3C, 1'b1);
    for (int k = 0; k < 100 && got_q.size() < BEATS; k++) step(1'b0, '0, bp[k % 4]);
    step(1'b0, '0, 1'b1);
    check("bp_cnt",  64'(got_q.size()), 64'(BEATS));
    check("bp_bits", pack_got(), fpack(8'h3C));

    // Ignored in_valid mid-frame
    got_q.delete();
    step(1'b1, 8'hF0, 1'b1);
    for (int i = 0; i < BEATS + 2; i++) step(i == 3, 8'h11, 1'b1);
    check("ign_cnt",  64'(got_q.size()), 64'(BEATS));
    check("ign_bits", pack_got(), fpack(8'hF0));

`ifdef PISO_PARITY_EN
    got_q.delete();
    step(1'b1, 8'h07, 1'b1);
    for (int i = 0; i < BEATS; i++) step(1'b0, '0, 1'b1);
    check("par07", 64'(got_q[W]), 64'd1);
    got_q.delete();
    step(1'b1, 8'h03, 1'b1);
    for (int i = 0; i < BEATS; i++) step(1'b0, '0, 1'b1);
    check("par03", 64'(got_q[W]), 64'd0);
`endif

    // Mid-frame reset after 3 beats, then a full frame of ones
    step(1'b1, 8'h5A, 1'b1);
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    #2;
    apply_reset();
    got_q.delete();
    step(1'b1, 8'hFF, 1'b1);
    for (int i = 0; i < BEATS; i++) step(1'b0, '0, 1'b1);
    check("post_rst_cnt",  64'(got_q.size()), 64'(BEATS));
    check("post_rst_bits", pack_got(), fpack(8'hFF));

    // Randomized traffic with occasional resets
    for (int c = 0; c < 2000; c++) begin
      if ($urandom_range(0, 299) == 0) apply_reset();
      else step(1'($urandom_range(0, 1)), W'($urandom), 1'($urandom_range(0, 3) != 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
